cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
//  Coprocessor-0 exception/interrupt controller: terminating end of the HWInt lines driven by the
//  bridge peripherals (TC Timer0/Timer1 IRQ, external interrupt). Holds SR/Cause/EPC/PRId.
//  Decides when the core takes an interrupt or exception, captures EPC, and serves mfc0/mtc0/eret.
//  Sits beside the M stage inside mips_in; the datapath flushes and redirects PC on exc_req.
// PARAMETERS
//  PRID      32'h2019_1207  read-only value of CP0 reg 15
//  HW_BITS   6              number of hardware interrupt lines (HWInt[5:0] -> IP/IM[15:10])
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//  rd_sel    in   5   mfc0 source register number
//  wr_sel    in   5   mtc0 destination register number
//  wr_en     in   1   mtc0 write strobe (M stage)
//  wr_data   in   32  mtc0 write data
//  pc_m      in   32  PC of instruction in M stage (word aligned)
//  bd_m      in   1   M-stage instruction sits in a branch delay slot
//  exc_code  in   5   synchronous exception code from M stage, 0 = none
//  exl_clr   in   1   eret in M stage
//  hw_int    in   6   HWInt {3'b0, interrupt, IRQ1, IRQ0}
//  exc_req   out  1   take exception/interrupt this cycle (combinational)
//  epc       out  32  EPC register value (eret target)
//  rd_data   out  32  mfc0 read data (combinational from rd_sel)
// BEHAVIOUR
//  Registers: SR(12)={16'b0,IM[15:10],8'b0,EXL[1],IE[0]}; Cause(13)={BD[31],15'b0,IP[15:10],
//   3'b0,ExcCode[6:2],2'b0}; EPC(14); PRId(15)=PRID. Other sel values read 32'h0, writes ignored.
//  Reset (reset==0, async): SR=0, Cause=0, EPC=0 -> exc_req=0, epc=0, rd_data per rd_sel.
//  IP: registered every cycle, IP<=hw_int (level, no latching); 1-cycle latency hw_int->exc_req.
//   mtc0 to Cause never alters IP/BD/ExcCode (Cause is read-only to software).
//  int_req = |(IP & IM) & IE & ~EXL.   sync_req = (exc_code!=0) & ~EXL.
//  exc_req = int_req | sync_req. Synchronous exception has priority over interrupt for ExcCode.
//  On clk edge with exc_req=1: EXL<=1; BD<=bd_m; EPC<= bd_m ? pc_m-4 : pc_m;
//   ExcCode<= sync_req ? exc_code : 5'd0. IM/IE unchanged.
//  On clk edge with exc_req=0: exl_clr -> EXL<=0; wr_en -> write SR (IM,EXL,IE only) or
//   EPC (wr_data[31:2],2'b00). wr_en and exl_clr same cycle: write applied first, then EXL<=0.
//  Simultaneous exc_req with wr_en or exl_clr: exc_req wins; the write and the clear are dropped
//   (instruction is flushed and re-executed after eret).
//  While EXL=1: no new exc_req of either kind (nested exceptions masked).
//  rd_data: current register value (pre-edge); no internal write-to-read bypass.
//  EPC wrap: pc_m-4 is 32-bit modulo arithmetic; pc_m=0 with bd_m=1 yields 32'hFFFF_FFFC.
//  Reset asserted mid-handler: all state cleared immediately, EXL=0, exc_req drops same cycle.
// STRUCTURE
//  Shared package cp0_pkg: register indices (SR=12, CAUSE=13, EPC=14, PRID=15), field bit
//   positions (IM_HI/LO, EXL, IE, IP_HI/LO, BD, EXC_HI/LO), ExcCode constants
//   (INT=0, ADEL=4, ADES=5, RI=10, OV=12); datapath decode and handler code use the same values.
//  No sub-module: four registers plus request logic in one module; mux for rd_data inline.
// TESTING
//  1 Reset: drive reset=0 with hw_int=6'h3F -> exc_req=0, rd_data(12/13/14)=0, (15)=PRID.
//  2 Timer IRQ: mtc0 SR=32'h0000_0401, hw_int=6'h01, pc_m=32'h3010 -> exc_req=1 one cycle later;
//    after edge EPC=32'h3010, Cause=32'h0000_0400, SR[1]=1, exc_req=0 while hw_int held.
//  3 Masking: SR=32'h0000_0801 (IM bit 11), hw_int=6'h01 -> exc_req stays 0 for 20 cycles;
//    SR IE=0 with matching IM -> exc_req 0.
//  4 Sync exc in delay slot: exc_code=12, bd_m=1, pc_m=32'h3020 -> EPC=32'h301C,
//    Cause=32'h8000_0030; same cycle hw_int=6'h01 with IM set -> ExcCode still 12.
//  5 Priority: exc_req and wr_en (EPC<=32'h1234) same cycle -> EPC=pc_m, write dropped;
//    exc_req and exl_clr same cycle -> EXL=1 after edge.
//  6 eret: EXL=1, exl_clr=1 with pending hw_int=6'h04 and IM[12]=1 -> EXL=0 after edge,
//    exc_req=1 in following cycle; async reset pulse mid-cycle clears EXL and EPC immediately.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field bit positions and exception codes.
// The datapath decoder and the exception handler software use the same values.
package cp0_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR field positions
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    // Cause field positions
    localparam int IP_HI  = 15;
    localparam int IP_LO  = 10;
    localparam int BD_BIT = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    // ExcCode values reported in Cause
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller.
// Holds SR/Cause/EPC/PRId, raises exc_req for the M stage, and serves mfc0/mtc0/eret.
// Interrupt lines are sampled into Cause.IP every cycle, so an interrupt reaches exc_req
// one cycle after it appears on hw_int.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h2019_1207,
    parameter int          HW_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rd_sel,
    input  logic [4:0]          wr_sel,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    input  logic [31:0]         pc_m,
    input  logic                bd_m,
    input  logic [4:0]          exc_code,
    input  logic                exl_clr,
    input  logic [HW_BITS-1:0]  hw_int,
    output logic                exc_req,
    output logic [31:0]         epc,
    output logic [31:0]         rd_data
);

    logic [HW_BITS-1:0] im;
    logic               exl;
    logic               ie;
    logic [HW_BITS-1:0] ip;
    logic               bd;
    logic [4:0]         exc_code_q;
    logic [31:0]        epc_q;

    logic               int_req;
    logic               sync_req;
    logic [31:0]        sr_val;
    logic [31:0]        cause_val;

    // Request decision: EXL masks both interrupts and synchronous exceptions
    always_comb begin
        int_req  = (|(ip & im)) & ie & ~exl;
        sync_req = (exc_code != 5'd0) & ~exl;
        exc_req  = int_req | sync_req;
    end

    // Assemble SR/Cause images and select the mfc0 read value (no write bypass)
    always_comb begin
        sr_val                    = '0;
        sr_val[IM_LO +: HW_BITS]  = im;
        sr_val[EXL_BIT]           = exl;
        sr_val[IE_BIT]            = ie;

        cause_val                 = '0;
        cause_val[BD_BIT]         = bd;
        cause_val[IP_LO +: HW_BITS] = ip;
        cause_val[EXC_LO +: 5]    = exc_code_q;

        case (rd_sel)
            REG_SR:    rd_data = sr_val;
            REG_CAUSE: rd_data = cause_val;
            REG_EPC:   rd_data = epc_q;
            REG_PRID:  rd_data = PRID;
            default:   rd_data = 32'h0;
        endcase
    end

    // Register update: exception entry beats mtc0 and eret, which are dropped with the flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            ip         <= '0;
            bd         <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'h0;
        end else begin
            ip <= hw_int;
            if (exc_req) begin
                exl        <= 1'b1;
                bd         <= bd_m;
                epc_q      <= bd_m ? (pc_m - 32'd4) : pc_m;
                exc_code_q <= sync_req ? exc_code : EXC_INT;
            end else begin
                if (wr_en && (wr_sel == REG_SR)) begin
                    im  <= wr_data[IM_LO +: HW_BITS];
                    exl <= wr_data[EXL_BIT];
                    ie  <= wr_data[IE_BIT];
                end
                if (wr_en && (wr_sel == REG_EPC)) begin
                    epc_q <= {wr_data[31:2], 2'b00};
                end
                if (exl_clr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus a randomized run
// compared against a register-level reference model of the CP0 rules.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'h2019_1207;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code;
    logic        exl_clr;
    logic [5:0]  hw_int;
    logic        exc_req;
    logic [31:0] epc;
    logic [31:0] rd_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: whole 32-bit register images
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_exc_ctrl #(.PRID(PRID), .HW_BITS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_sel   (rd_sel),
        .wr_sel   (wr_sel),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pc_m     (pc_m),
        .bd_m     (bd_m),
        .exc_code (exc_code),
        .exl_clr  (exl_clr),
        .hw_int   (hw_int),
        .exc_req  (exc_req),
        .epc      (epc),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Model: request taken when an enabled interrupt is pending or a sync exception arrives, unless EXL
    function automatic logic m_req();
        logic [5:0] pend;
        pend = m_cause[15:10] & m_sr[15:10];
        return (((pend != 6'd0) && m_sr[0]) || (exc_code != 5'd0)) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] sel);
        case (sel)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr    = 32'h0;
        m_cause = 32'h0;
        m_epc   = 32'h0;
    endtask

    // Model clock edge, evaluated with the inputs present just before the edge
    task automatic model_edge();
        logic take;
        if (!reset) begin
            model_reset();
            return;
        end
        take = m_req();
        if (take) begin
            m_sr[1]     = 1'b1;
            m_cause[31] = bd_m;
            m_cause[6:2] = exc_code;
            m_epc       = bd_m ? pc_m - 32'd4 : pc_m;
        end else begin
            if (wr_en && wr_sel == 5'd12) m_sr  = wr_data & 32'h0000_FC03;
            if (wr_en && wr_sel == 5'd14) m_epc = wr_data & 32'hFFFF_FFFC;
            if (exl_clr) m_sr[1] = 1'b0;
        end
        m_cause[15:10] = hw_int;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_sel   = 5'd0;
        wr_sel   = 5'd0;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        pc_m     = 32'h0;
        bd_m     = 1'b0;
        exc_code = 5'd0;
        exl_clr  = 1'b0;
        hw_int   = 6'h0;
    endtask

    task automatic read_reg(input logic [4:0] sel, output logic [31:0] val);
        rd_sel = sel;
        #1;
        val = rd_data;
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic eret();
        exl_clr = 1'b1;
        step();
        exl_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle_inputs();
        reset  = 1'b0;
        hw_int = 6'h3F;
        model_reset();
        #1;
        vectors++;
        if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req got %b want 0", exc_req); end
        vectors++;
        if (epc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_epc got %h want 0", epc); end
        for (int s = 12; s <= 15; s++) begin
            read_reg(5'(s), v);
            vectors++;
            if (v !== ((s == 15) ? PRID : 32'h0)) begin
                miscompares++;
                $display("[TB] FAIL reset_rd%0d got %h want %h", s, v, (s == 15) ? PRID : 32'h0);
            end
        end
        step();
        step();
        vectors++;
        if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req_held got %b want 0", exc_req); end
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cause_held got %h want 0", v); end
        hw_int = 6'h0;
        reset  = 1'b1;
        step();
    endtask

    task automatic test_timer_irq();
        logic [31:0] v;
        idle_inputs();
        hw_int = 6'h01;
        pc_m   = 32'h3010;
        mtc0(5'd12, 32'h0000_0401);
        #1;
        vectors++;
        if (exc_req !== 1'b1) begin miscompares++; $display("[TB] FAIL timer_req got %b want 1", exc_req); end
        step();
        vectors++;
        if (epc !== 32'h3010) begin miscompares++; $display("[TB] FAIL timer_epc got %h want 00003010", epc); end
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h0000_0400) begin miscompares++; $display("[TB] FAIL timer_cause got %h want 00000400", v); end
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0000_0403) begin miscompares++; $display("[TB] FAIL timer_sr got %h want 00000403", v); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL timer_held_req got %b want 0", exc_req); end
            step();
        end
        hw_int = 6'h0;
        eret();
        step();
    endtask

    task automatic test_masking();
        idle_inputs();
        hw_int = 6'h01;
        mtc0(5'd12, 32'h0000_0801);
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_im_req cyc %0d got %b want 0", i, exc_req); end
            step();
        end
        mtc0(5'd12, 32'h0000_0400);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_ie_req cyc %0d got %b want 0", i, exc_req); end
            step();
        end
        hw_int = 6'h0;
        step();
    endtask

    task automatic test_delay_slot();
        logic [31:0] v;
        idle_inputs();
        mtc0(5'd12, 32'h0000_0401);
        exc_code = 5'd12;
        bd_m     = 1'b1;
        pc_m     = 32'h3020;
        #1;
        vectors++;
        if (exc_req !== 1'b1) begin miscompares++; $display("[TB] FAIL ds_req got %b want 1", exc_req); end
        step();
        exc_code = 5'd0;
        bd_m     = 1'b0;
        vectors++;
        if (epc !== 32'h301C) begin miscompares++; $display("[TB] FAIL ds_epc got %h want 0000301c", epc); end
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h8000_0030) begin miscompares++; $display("[TB] FAIL ds_cause got %h want 80000030", v); end
        eret();
        // interrupt pending at the same time as an overflow: ExcCode must report the overflow
        hw_int = 6'h01;
        step();
        exc_code = 5'd12;
        pc_m     = 32'h3040;
        step();
        exc_code = 5'd0;
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h0000_0430) begin miscompares++; $display("[TB] FAIL ds_prio_cause got %h want 00000430", v); end
        vectors++;
        if (epc !== 32'h3040) begin miscompares++; $display("[TB] FAIL ds_prio_epc got %h want 00003040", epc); end
        hw_int = 6'h0;
        eret();
        // delay slot at address 0 wraps the EPC
        exc_code = 5'd10;
        bd_m     = 1'b1;
        pc_m     = 32'h0;
        step();
        exc_code = 5'd0;
        bd_m     = 1'b0;
        vectors++;
        if (epc !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL ds_wrap_epc got %h want fffffffc", epc); end
        eret();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        idle_inputs();
        exc_code = 5'd4;
        pc_m     = 32'h4000;
        wr_en    = 1'b1;
        wr_sel   = 5'd14;
        wr_data  = 32'h1234;
        step();
        idle_inputs();
        vectors++;
        if (epc !== 32'h4000) begin miscompares++; $display("[TB] FAIL prio_wr_epc got %h want 00004000", epc); end
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0000_0403) begin miscompares++; $display("[TB] FAIL prio_wr_sr got %h want 00000403", v); end
        eret();
        exc_code = 5'd5;
        pc_m     = 32'h5000;
        exl_clr  = 1'b1;
        step();
        idle_inputs();
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0000_0403) begin miscompares++; $display("[TB] FAIL prio_clr_sr got %h want 00000403", v); end
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h0000_0014) begin miscompares++; $display("[TB] FAIL prio_clr_cause got %h want 00000014", v); end
        eret();
        // write and eret together: write lands, then EXL is cleared
        exl_clr = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        exl_clr = 1'b0;
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0000_0401) begin miscompares++; $display("[TB] FAIL wr_clr_sr got %h want 00000401", v); end
        mtc0(5'd14, 32'h0000_1237);
        vectors++;
        if (epc !== 32'h1234) begin miscompares++; $display("[TB] FAIL epc_align got %h want 00001234", epc); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        read_reg(5'd13, v);
        vectors++;
        if (v !== 32'h0000_0014) begin miscompares++; $display("[TB] FAIL cause_ro got %h want 00000014", v); end
    endtask

    task automatic test_eret();
        logic [31:0] v;
        idle_inputs();
        mtc0(5'd12, 32'h0000_1001);
        exc_code = 5'd10;
        pc_m     = 32'h6000;
        step();
        exc_code = 5'd0;
        hw_int   = 6'h04;
        step();
        vectors++;
        if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL eret_nested_req got %b want 0", exc_req); end
        exl_clr = 1'b1;
        step();
        exl_clr = 1'b0;
        #1;
        vectors++;
        if (exc_req !== 1'b1) begin miscompares++; $display("[TB] FAIL eret_pending_req got %b want 1", exc_req); end
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0000_1001) begin miscompares++; $display("[TB] FAIL eret_sr got %h want 00001001", v); end
        pc_m = 32'h6100;
        step();
        vectors++;
        if (epc !== 32'h6100) begin miscompares++; $display("[TB] FAIL eret_irq_epc got %h want 00006100", epc); end
        // asynchronous reset in the middle of the handler
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (exc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL async_req got %b want 0", exc_req); end
        vectors++;
        if (epc !== 32'h0) begin miscompares++; $display("[TB] FAIL async_epc got %h want 0", epc); end
        read_reg(5'd12, v);
        vectors++;
        if (v !== 32'h0) begin miscompares++; $display("[TB] FAIL async_sr got %h want 0", v); end
        hw_int = 6'h0;
        reset  = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [4:0] codes [4];
        logic       exp_req;
        logic [31:0] exp_rd;
        codes = '{5'd4, 5'd5, 5'd10, 5'd12};
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rd_sel   = 5'(10 + $urandom_range(0, 7));
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_sel   = 5'(11 + $urandom_range(0, 5));
            wr_data  = $urandom;
            pc_m     = $urandom & 32'hFFFF_FFFC;
            bd_m     = 1'($urandom_range(0, 1));
            exc_code = ($urandom_range(0, 99) < 15) ? codes[$urandom_range(0, 3)] : 5'd0;
            exl_clr  = ($urandom_range(0, 99) < 15);
            hw_int   = ($urandom_range(0, 99) < 25) ? 6'($urandom) : 6'h0;
            #1;
            exp_req = m_req();
            exp_rd  = m_read(rd_sel);
            vectors++;
            if (exc_req !== exp_req) begin miscompares++; $display("[TB] FAIL rand_req cyc %0d got %b want %b", i, exc_req, exp_req); end
            vectors++;
            if (rd_data !== exp_rd) begin miscompares++; $display("[TB] FAIL rand_rd sel %0d cyc %0d got %h want %h", rd_sel, i, rd_data, exp_rd); end
            vectors++;
            if (epc !== m_epc) begin miscompares++; $display("[TB] FAIL rand_epc cyc %0d got %h want %h", i, epc, m_epc); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_timer_irq();
        test_masking();
        test_delay_slot();
        test_priority();
        test_eret();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
